// File: rtl/rotor_step_controller_if.sv
// rtl/rotor_step_controller_if.sv - letter stream handshake (valid/ready/letter)
interface rotor_step_controller_if;
    logic       valid;
    logic       ready;
    logic [4:0] letter;

    modport master (output valid, output letter, input ready);
    modport slave  (input valid, input letter, output ready);
endinterface

// File: rtl/rotor_step_controller.sv
// rtl/rotor_step_controller.sv - three-rotor Enigma stepping sequencer with settle/capture handshake
module rotor_step_controller #(
    parameter int NOTCH_R       = 21,
    parameter int NOTCH_M       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    rotor_step_controller_if.slave  key,
    input  logic                    cfg_load,
    input  logic [4:0]              cfg_pos_l,
    input  logic [4:0]              cfg_pos_m,
    input  logic [4:0]              cfg_pos_r,
    output logic [4:0]              pos_l,
    output logic [4:0]              pos_m,
    output logic [4:0]              pos_r,
    output logic                    step_l,
    output logic                    step_m,
    output logic                    step_r,
    output logic [4:0]              path_letter,
    input  logic [4:0]              path_result,
    rotor_step_controller_if.master result,
    output logic                    busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int         CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [4:0] NR = 5'(NOTCH_R);
    localparam logic [4:0] NM = 5'(NOTCH_M);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [4:0]    key_lat;
    logic          key_bad;

    function automatic logic [4:0] adv(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] clamp(input logic [4:0] p);
        return (p < 5'd26) ? p : 5'd0;
    endfunction

    assign key_bad   = (key_lat >= 5'd26);
    assign key.ready = (state == S_IDLE) && !cfg_load;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            key_lat       <= 5'd0;
            pos_l         <= 5'd0;
            pos_m         <= 5'd0;
            pos_r         <= 5'd0;
            step_l        <= 1'b0;
            step_m        <= 1'b0;
            step_r        <= 1'b0;
            path_letter   <= 5'd0;
            result.letter <= 5'd0;
            result.valid  <= 1'b0;
        end else begin
            step_l <= 1'b0;
            step_m <= 1'b0;
            step_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_load) begin
                        pos_l <= clamp(cfg_pos_l);
                        pos_m <= clamp(cfg_pos_m);
                        pos_r <= clamp(cfg_pos_r);
                    end else if (key.valid) begin
                        key_lat <= key.letter;
                        state   <= S_STEP;
                    end
                end
                S_STEP: begin
                    // Carry decisions use pre-step positions; middle double-steps on its own notch.
                    if (!key_bad) begin
                        pos_r  <= adv(pos_r);
                        step_r <= 1'b1;
                        if (pos_r == NR || pos_m == NM) begin
                            pos_m  <= adv(pos_m);
                            step_m <= 1'b1;
                        end
                        if (pos_m == NM) begin
                            pos_l  <= adv(pos_l);
                            step_l <= 1'b1;
                        end
                        path_letter <= key_lat;
                    end else begin
                        path_letter <= 5'd0;
                    end
                    cnt   <= CW'(SETTLE_CYCLES - 1);
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        result.letter <= key_bad ? 5'd31 : path_result;
                        result.valid  <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (result.ready) begin
                        result.valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rotor_step_controller.sv
// tb/tb_rotor_step_controller.sv - directed scoreboard bench for rotor_step_controller
module tb_rotor_step_controller;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rotor_step_controller_if key_a ();
    rotor_step_controller_if res_a ();
    rotor_step_controller_if key_b ();
    rotor_step_controller_if res_b ();

    logic       cfg_load, b_cfg_load;
    logic [4:0] cfg_l, cfg_m, cfg_r, b_cfg;
    logic [4:0] pos_l, pos_m, pos_r, b_pos_l, b_pos_m, b_pos_r;
    logic       step_l, step_m, step_r, b_step_l, b_step_m, b_step_r;
    logic [4:0] path_letter, path_result, b_path_letter, b_path_result;
    logic       busy, b_busy;

    rotor_step_controller dut (
        .clock(clock), .reset(reset), .key(key_a),
        .cfg_load(cfg_load), .cfg_pos_l(cfg_l), .cfg_pos_m(cfg_m), .cfg_pos_r(cfg_r),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .step_l(step_l), .step_m(step_m), .step_r(step_r),
        .path_letter(path_letter), .path_result(path_result),
        .result(res_a), .busy(busy)
    );

    rotor_step_controller #(.NOTCH_R(25), .NOTCH_M(25), .SETTLE_CYCLES(2)) dut_wrap (
        .clock(clock), .reset(reset), .key(key_b),
        .cfg_load(b_cfg_load), .cfg_pos_l(b_cfg), .cfg_pos_m(b_cfg), .cfg_pos_r(b_cfg),
        .pos_l(b_pos_l), .pos_m(b_pos_m), .pos_r(b_pos_r),
        .step_l(b_step_l), .step_m(b_step_m), .step_r(b_step_r),
        .path_letter(b_path_letter), .path_result(b_path_result),
        .result(res_b), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_key(input logic [4:0] k, input logic [4:0] res, input logic [2:0] es,
                          input logic [14:0] ep, input int hold, input bit cfg_busy);
        int lat;
        logic [4:0] held;
        exp_q.push_back((k >= 5'd26) ? 5'd31 : res);
        path_result  = res;
        res_a.ready  = (hold == 0);
        key_a.valid  = 1'b1;
        key_a.letter = k;
        lat = 0;
        while (!key_a.ready && lat < 20) begin
            tick;
            lat++;
        end
        check("key_ready_before_accept", 32'(key_a.ready), 1);
        tick;
        key_a.valid = 1'b0;
        tick;
        check("step_pulse", 32'({step_l, step_m, step_r}), 32'(es));
        check("pos_after_step", 32'({pos_l, pos_m, pos_r}), 32'(ep));
        check("path_letter", 32'(path_letter), (k < 5'd26) ? 32'(k) : 0);
        if (cfg_busy) begin
            cfg_load = 1'b1; cfg_l = 5'd7; cfg_m = 5'd7; cfg_r = 5'd7;
        end
        tick;
        lat = 2;
        check("step_one_cycle", 32'({step_l, step_m, step_r}), 0);
        while (!res_a.valid && lat < 20) begin
            tick;
            lat++;
        end
        check("latency", 32'(lat), 3);
        check("out_letter", 32'(res_a.letter), 32'(exp_q.pop_front()));
        cfg_load = 1'b0;
        if (hold > 0) begin
            held         = res_a.letter;
            key_a.valid  = 1'b1;
            key_a.letter = 5'd9;
            for (int i = 0; i < hold; i++) begin
                tick;
                check("bp_valid", 32'(res_a.valid), 1);
                check("bp_letter", 32'(res_a.letter), 32'(held));
                check("bp_key_ready", 32'(key_a.ready), 0);
            end
            key_a.valid = 1'b0;
            res_a.ready = 1'b1;
        end
        tick;
        check("valid_drop", 32'(res_a.valid), 0);
        check("back_to_idle", 32'(busy), 0);
        check("pos_stable", 32'({pos_l, pos_m, pos_r}), 32'(ep));
    endtask

    initial begin
        reset = 1'b1;
        key_a.valid = 1'b0; key_a.letter = 5'd0; res_a.ready = 1'b1;
        key_b.valid = 1'b0; key_b.letter = 5'd0; res_b.ready = 1'b1;
        cfg_load = 1'b0; cfg_l = 5'd0; cfg_m = 5'd0; cfg_r = 5'd0;
        b_cfg_load = 1'b0; b_cfg = 5'd0; b_path_result = 5'd0;
        path_result = 5'd0;
        tick;
        tick;
        check("rst_pos", 32'({pos_l, pos_m, pos_r}), 0);
        check("rst_step", 32'({step_l, step_m, step_r}), 0);
        check("rst_out_valid", 32'(res_a.valid), 0);
        check("rst_out_letter", 32'(res_a.letter), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        #1;
        check("rst_key_ready", 32'(key_a.ready), 1);

        // Reset asserted while the first key is settling
        path_result = 5'd5; key_a.valid = 1'b1; key_a.letter = 5'd0;
        tick;
        key_a.valid = 1'b0;
        tick;
        tick;
        check("mid_settle_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_pos", 32'({pos_l, pos_m, pos_r}), 0);
        check("async_rst_path", 32'(path_letter), 0);
        check("async_rst_valid", 32'(res_a.valid), 0);
        tick;
        reset = 1'b0;
        tick;

        do_key(5'd0, 5'd5, 3'b001, {5'd0, 5'd0, 5'd1}, 0, 1'b0);

        // Load collides with a key offer: load wins
        cfg_load = 1'b1; cfg_l = 5'd0; cfg_m = 5'd3; cfg_r = 5'd20;
        key_a.valid = 1'b1; key_a.letter = 5'd1;
        #1;
        check("collide_key_ready", 32'(key_a.ready), 0);
        tick;
        cfg_load = 1'b0; key_a.valid = 1'b0;
        check("load_pos", 32'({pos_l, pos_m, pos_r}), 32'({5'd0, 5'd3, 5'd20}));
        check("collide_no_step", 32'({step_l, step_m, step_r}), 0);
        tick;
        check("collide_not_accepted", 32'(busy), 0);

        do_key(5'd1, 5'd7,  3'b001, {5'd0, 5'd3, 5'd21}, 0, 1'b0);
        do_key(5'd2, 5'd8,  3'b011, {5'd0, 5'd4, 5'd22}, 0, 1'b0);
        do_key(5'd3, 5'd9,  3'b111, {5'd1, 5'd5, 5'd23}, 0, 1'b1);
        do_key(5'd4, 5'd10, 3'b001, {5'd1, 5'd5, 5'd24}, 10, 1'b0);
        do_key(5'd28, 5'd12, 3'b000, {5'd1, 5'd5, 5'd24}, 0, 1'b0);

        cfg_load = 1'b1; cfg_l = 5'd5; cfg_m = 5'd6; cfg_r = 5'd30;
        tick;
        cfg_load = 1'b0;
        check("load_clamp", 32'({pos_l, pos_m, pos_r}), 32'({5'd5, 5'd6, 5'd0}));

        // All three rotors wrap together with notches at 25
        b_cfg_load = 1'b1; b_cfg = 5'd25;
        tick;
        b_cfg_load = 1'b0;
        check("wrap_load", 32'({b_pos_l, b_pos_m, b_pos_r}), 32'({5'd25, 5'd25, 5'd25}));
        key_b.valid = 1'b1; key_b.letter = 5'd2;
        tick;
        key_b.valid = 1'b0;
        tick;
        check("wrap_steps", 32'({b_step_l, b_step_m, b_step_r}), 32'(3'b111));
        check("wrap_pos", 32'({b_pos_l, b_pos_m, b_pos_r}), 0);
        tick;
        check("wrap_step_one_cycle", 32'({b_step_l, b_step_m, b_step_r}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
